ad9767_scheduler: RTL

Sample scheduler and rate controller that feeds the dual-channel AD9767 DDR output stage. Two independent ready/valid sample streams (channel A, channel B) are buffered in small FIFOs and released to the DAC stage at a programmable update rate, in either lock-step or independent mode. The block handles underflow with a selectable hold/zero policy and parks both channels at mid-scale on stop. It sits between the signal-generation logic and the DAC output stage, in the `dac_clk_i` domain.

---
 rtl/ad9767_scheduler_pkg.sv | 15 +
 rtl/ad9767_scheduler_sample_fifo.sv | 53 +++++
 rtl/ad9767_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ad9767_scheduler_pkg.sv
// Shared definitions for the AD9767 sample scheduler: FSM state encodings and the
// mid-scale code the outputs park at.
package ad9767_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_PARK  = 2'd3
  } state_t;

  // Two's complement 0 is mid-scale for the DAC.
  localparam int ZERO_CODE = 0;

endpackage

// File: rtl/ad9767_scheduler_sample_fifo.sv
// Small synchronous first-word-fall-through FIFO; the head word is readable
// whenever empty is low. Flush clears both pointers and wins over push/pop.
module sample_fifo #(
  parameter int DATA_WIDTH = 14,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  push_ok;
  logic                  pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ad9767_scheduler.sv
// Two-channel sample scheduler for the AD9767 output stage: buffers A/B streams
// and releases them at a programmable rate, in lock-step or independently.
module ad9767_scheduler
  import ad9767_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  sync_mode_i,
  input  logic                  underflow_zero_i,
  input  logic                  clr_status_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic                  data_a_valid_i,
  input  logic                  data_b_valid_i,
  output logic                  data_a_ready_o,
  output logic                  data_b_ready_o,
  output logic [DATA_WIDTH-1:0] dac_dat_a_o,
  output logic [DATA_WIDTH-1:0] dac_dat_b_o,
  output logic                  dac_dat_a_en_o,
  output logic                  dac_dat_b_en_o,
  output logic                  busy_o,
  output logic                  underflow_a_o,
  output logic                  underflow_b_o
);

  localparam logic [DATA_WIDTH-1:0] ZERO_SAMPLE = DATA_WIDTH'(ZERO_CODE);

  state_t                state_reg, state_next;
  logic [DIV_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] dat_reg  [2];
  logic [DATA_WIDTH-1:0] dat_next [2];
  logic [DATA_WIDTH-1:0] head     [2];
  logic [1:0]            en_reg, en_next;
  logic [1:0]            uf_reg, uf_set;
  logic [1:0]            valid, full, empty, pop;
  logic                  flush;
  logic                  tick;
  logic                  prime_ok;
  logic                  stopping;

  assign valid = {data_b_valid_i, data_a_valid_i};
  // A stop from IDLE flushes immediately; from PRIME/RUN it flushes now and again in PARK.
  assign flush = stop_i || (state_reg == ST_PARK);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (dac_clk_i),
        .rst     (dac_rst_i),
        .push    (valid[gi]),
        .pop     (pop[gi]),
        .flush   (flush),
        .wr_data ((gi == 0) ? data_a_i : data_b_i),
        .rd_data (head[gi]),
        .full    (full[gi]),
        .empty   (empty[gi])
      );
    end
  endgenerate

  assign prime_ok = sync_mode_i ? ~|empty : ~&empty;
  assign stopping = stop_i && ((state_reg == ST_PRIME) || (state_reg == ST_RUN));
  assign tick     = (state_reg == ST_RUN) && !stop_i && (cnt_reg == '0);

  // State register and status/output registers.
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      en_reg    <= '0;
      uf_reg    <= '0;
      for (int i = 0; i < 2; i++) dat_reg[i] <= ZERO_SAMPLE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      en_reg    <= en_next;
      for (int i = 0; i < 2; i++) begin
        dat_reg[i] <= dat_next[i];
        uf_reg[i]  <= uf_set[i] || (uf_reg[i] && !clr_status_i);
      end
    end
  end

  // Next-state and rate divider.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!stop_i && start_i) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        cnt_next = '0;
        if (stop_i)        state_next = ST_PARK;
        else if (prime_ok) state_next = ST_RUN;
      end
      ST_RUN: begin
        cnt_next = (cnt_reg == '0) ? div_i : cnt_reg - DIV_WIDTH'(1);
        if (stop_i) state_next = ST_PARK;
      end
      ST_PARK: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Pop, strobe and underflow decisions for the current cycle.
  always_comb begin
    pop     = '0;
    en_next = '0;
    uf_set  = '0;
    for (int i = 0; i < 2; i++) dat_next[i] = dat_reg[i];
    if (stopping) begin
      en_next = '1;
      for (int i = 0; i < 2; i++) dat_next[i] = ZERO_SAMPLE;
    end else if (tick) begin
      if (sync_mode_i) begin
        if (~|empty) begin
          pop     = '1;
          en_next = '1;
          for (int i = 0; i < 2; i++) dat_next[i] = head[i];
        end else begin
          uf_set = empty;
          if (underflow_zero_i) begin
            en_next = '1;
            for (int i = 0; i < 2; i++) dat_next[i] = ZERO_SAMPLE;
          end
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!empty[i]) begin
            pop[i]      = 1'b1;
            en_next[i]  = 1'b1;
            dat_next[i] = head[i];
          end else begin
            uf_set[i] = 1'b1;
            if (underflow_zero_i) begin
              en_next[i]  = 1'b1;
              dat_next[i] = ZERO_SAMPLE;
            end
          end
        end
      end
    end
  end

  assign data_a_ready_o = !full[0];
  assign data_b_ready_o = !full[1];
  assign dac_dat_a_o    = dat_reg[0];
  assign dac_dat_b_o    = dat_reg[1];
  assign dac_dat_a_en_o = en_reg[0];
  assign dac_dat_b_en_o = en_reg[1];
  assign underflow_a_o  = uf_reg[0];
  assign underflow_b_o  = uf_reg[1];
  assign busy_o         = (state_reg == ST_PRIME) || (state_reg == ST_RUN);

endmodule
